// File: rtl/fg_prog_sequencer.sv
// Floating-gate programming sequencer: selects one island cell and drives
// timed injection/tunnelling pulse trains through the programming mux.
//
// Ports:
//   clk, rst_n            - rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready   - command handshake (ready only when idle)
//   cmd_row, cmd_col      - target cell address
//   cmd_mode              - 0 = injection (vinj_pulse), 1 = tunnelling
//   cmd_npulse            - pulse count, 0 = select/deselect only
//   cmd_width, cmd_gap    - pulse high/low time in cycles (width 0 -> 1)
//   vdec_addr, hdec_addr  - vertical/horizontal decoder addresses
//   prog_sel, drain_sel   - route prog switch and drain to the cell
//   vinj_pulse, tun_pulse - registered high-voltage pulse enables
//   busy, done, err       - status; done and err are 1-cycle pulses
module fg_prog_sequencer #(
    parameter int NUM_ROWS = 50,
    parameter int NUM_COLS = 4,
    parameter int ROW_W    = 6,
    parameter int COL_W    = 2,
    parameter int SETTLE   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [COL_W-1:0] cmd_col,
    input  logic             cmd_mode,
    input  logic [7:0]       cmd_npulse,
    input  logic [15:0]      cmd_width,
    input  logic [15:0]      cmd_gap,
    output logic [ROW_W-1:0] vdec_addr,
    output logic [COL_W-1:0] hdec_addr,
    output logic             prog_sel,
    output logic             drain_sel,
    output logic             vinj_pulse,
    output logic             tun_pulse,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_RELEASE,
        S_DONE
    } state_e;

    // Timers count down to 0, so a phase of N cycles loads N-1.
    localparam logic [15:0] SETTLE_M1 =
        (SETTLE > 1) ? 16'(SETTLE - 1) : 16'd0;
    localparam logic [31:0] ROWS_L = 32'(NUM_ROWS);
    localparam logic [31:0] COLS_L = 32'(NUM_COLS);

    state_e           state_q, state_d;
    logic [15:0]      timer_q, timer_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic             mode_q, mode_d;
    logic [15:0]      width_q, width_d;
    logic [15:0]      gap_q, gap_d;
    logic [ROW_W-1:0] vdec_q, vdec_d;
    logic [COL_W-1:0] hdec_q, hdec_d;
    logic             prog_q, prog_d;
    logic             drain_q, drain_d;
    logic             vinj_q, vinj_d;
    logic             tun_q, tun_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    logic             accept;
    logic             cmd_bad;
    logic             in_cell;
    logic [15:0]      width_m1;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pcnt_d   = pcnt_q;
        mode_d   = mode_q;
        width_d  = width_q;
        gap_d    = gap_q;
        vdec_d   = vdec_q;
        hdec_d   = hdec_q;
        err_d    = 1'b0;

        accept   = cmd_valid && (state_q == S_IDLE);
        cmd_bad  = (32'(cmd_row) >= ROWS_L) ||
                   (32'(cmd_col) >= COLS_L);
        width_m1 = (width_q == 16'd0) ? 16'd0 : width_q - 16'd1;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        vdec_d  = cmd_row;
                        hdec_d  = cmd_col;
                        mode_d  = cmd_mode;
                        pcnt_d  = cmd_npulse;
                        width_d = cmd_width;
                        gap_d   = cmd_gap;
                        timer_d = SETTLE_M1;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (timer_q == 16'd0) begin
                    if (pcnt_q == 8'd0) begin
                        timer_d = SETTLE_M1;
                        state_d = S_RELEASE;
                    end else begin
                        timer_d = width_m1;
                        state_d = S_PULSE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_PULSE: begin
                if (timer_q == 16'd0) begin
                    pcnt_d = pcnt_q - 8'd1;
                    if (pcnt_q == 8'd1) begin
                        timer_d = SETTLE_M1;
                        state_d = S_RELEASE;
                    end else if (gap_q == 16'd0) begin
                        // Back-to-back pulse: stay high, reload width.
                        timer_d = width_m1;
                        state_d = S_PULSE;
                    end else begin
                        timer_d = gap_q - 16'd1;
                        state_d = S_GAP;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_GAP: begin
                if (timer_q == 16'd0) begin
                    timer_d = width_m1;
                    state_d = S_PULSE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_RELEASE: begin
                if (timer_q == 16'd0) begin
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // and line up with the state they describe.
        in_cell = (state_d == S_SETUP) || (state_d == S_PULSE) ||
                  (state_d == S_GAP)   || (state_d == S_RELEASE);
        prog_d  = in_cell;
        drain_d = in_cell;
        vinj_d  = (state_d == S_PULSE) && !mode_d;
        tun_d   = (state_d == S_PULSE) && mode_d;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= 16'd0;
            pcnt_q  <= 8'd0;
            mode_q  <= 1'b0;
            width_q <= 16'd0;
            gap_q   <= 16'd0;
            vdec_q  <= '0;
            hdec_q  <= '0;
            prog_q  <= 1'b0;
            drain_q <= 1'b0;
            vinj_q  <= 1'b0;
            tun_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            // Ready out of reset so the first edge can accept a command.
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pcnt_q  <= pcnt_d;
            mode_q  <= mode_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            vdec_q  <= vdec_d;
            hdec_q  <= hdec_d;
            prog_q  <= prog_d;
            drain_q <= drain_d;
            vinj_q  <= vinj_d;
            tun_q   <= tun_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign vdec_addr  = vdec_q;
    assign hdec_addr  = hdec_q;
    assign prog_sel   = prog_q;
    assign drain_sel  = drain_q;
    assign vinj_pulse = vinj_q;
    assign tun_pulse  = tun_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Testbench for fg_prog_sequencer: table vectors, corner sequences and
// random commands checked cycle by cycle against a waveform model.
module tb_fg_prog_sequencer;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_row = '0;
    logic [1:0]  cmd_col = '0;
    logic        cmd_mode = 1'b0;
    logic [7:0]  cmd_npulse = '0;
    logic [15:0] cmd_width = '0;
    logic [15:0] cmd_gap = '0;
    logic [5:0]  vdec_addr;
    logic [1:0]  hdec_addr;
    logic        prog_sel, drain_sel, vinj_pulse, tun_pulse;
    logic        busy, done, err;

    fg_prog_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_mode(cmd_mode), .cmd_npulse(cmd_npulse),
        .cmd_width(cmd_width), .cmd_gap(cmd_gap),
        .vdec_addr(vdec_addr), .hdec_addr(hdec_addr),
        .prog_sel(prog_sel), .drain_sel(drain_sel),
        .vinj_pulse(vinj_pulse), .tun_pulse(tun_pulse),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  row;
        logic [1:0]  col;
        logic        mode;
        logic [7:0]  npulse;
        logic [15:0] width;
        logic [15:0] gap;
    } cmd_t;

    typedef struct packed {
        cmd_t c;
        int   exp_err;
        int   exp_len;
        int   exp_high;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [5:0] exp_row = '0;
    logic [1:0] exp_col = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_bad(cmd_t c);
        return (int'(c.row) >= 50) || (int'(c.col) >= 4);
    endfunction

    function automatic int train_len(cmd_t c);
        int w;
        int n;
        w = (c.width == 0) ? 1 : int'(c.width);
        n = int'(c.npulse);
        return (n == 0) ? 0 : n * w + (n - 1) * int'(c.gap);
    endfunction

    // Cycle index (1 = first cycle after acceptance) at which done shows.
    function automatic int done_at(cmd_t c);
        return is_bad(c) ? 0 : 2 * S + train_len(c) + 1;
    endfunction

    // Expected {ready,busy,done,err,prog,drain,vinj,tun} on cycle k.
    function automatic logic [7:0] exp_vec(cmd_t c, int k);
        int w;
        int p;
        int j;
        logic [7:0] sel;
        w   = (c.width == 0) ? 1 : int'(c.width);
        p   = train_len(c);
        sel = 8'b0100_1100;
        if (is_bad(c))
            return (k == 1) ? 8'b1001_0000 : 8'b1000_0000;
        if (k <= S)
            return sel;
        if (k <= S + p) begin
            j = k - S - 1;
            if ((j % (w + int'(c.gap))) < w)
                return sel | (c.mode ? 8'b0000_0001 : 8'b0000_0010);
            return sel;
        end
        if (k <= 2 * S + p)
            return sel;
        if (k == 2 * S + p + 1)
            return 8'b0110_0000;
        return 8'b1000_0000;
    endfunction

    function automatic logic [7:0] obs();
        return {cmd_ready, busy, done, err, prog_sel, drain_sel,
                vinj_pulse, tun_pulse};
    endfunction

    task automatic drive(input cmd_t c, input logic v);
        cmd_row    = c.row;
        cmd_col    = c.col;
        cmd_mode   = c.mode;
        cmd_npulse = c.npulse;
        cmd_width  = c.width;
        cmd_gap    = c.gap;
        cmd_valid  = v;
    endtask

    task automatic scramble_inputs();
        cmd_row    = 6'($urandom);
        cmd_col    = 2'($urandom);
        cmd_mode   = 1'($urandom);
        cmd_npulse = 8'($urandom);
        cmd_width  = 16'($urandom);
        cmd_gap    = 16'($urandom);
        cmd_valid  = 1'($urandom);
    endtask

    task automatic run_cmd(input cmd_t c, input bit scramble,
                           input bit now, output int o_len,
                           output int o_high, output int o_err);
        int total;
        logic [7:0] act;
        total = is_bad(c) ? 1 : done_at(c);
        if (!now) @(negedge clk);
        drive(c, 1'b1);
        if (!is_bad(c)) begin
            exp_row = c.row;
            exp_col = c.col;
        end
        o_len  = 0;
        o_high = 0;
        o_err  = 0;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            act = obs();
            check($sformatf("trace r%0d c%0d k%0d", c.row, c.col, k),
                  32'(act), 32'(exp_vec(c, k)));
            check($sformatf("addr k%0d", k), {vdec_addr, hdec_addr},
                  {exp_row, exp_col});
            if (act[5]) o_len = k;
            if (act[1] | act[0]) o_high++;
            if (act[4]) o_err++;
            if (scramble && k < total) scramble_inputs();
            else cmd_valid = 1'b0;
        end
    endtask

    function automatic cmd_t mk(int r, int cc, int m, int n, int w, int g);
        cmd_t c;
        c.row    = 6'(r);
        c.col    = 2'(cc);
        c.mode   = 1'(m);
        c.npulse = 8'(n);
        c.width  = 16'(w);
        c.gap    = 16'(g);
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        cmd_t c;
        int   len, high, nerr, n, ndone;

        tbl[0] = '{mk(3, 1, 0, 2, 4, 3), 0, 28, 8};
        tbl[1] = '{mk(50, 0, 0, 1, 1, 1), 1, 0, 0};
        tbl[2] = '{mk(10, 2, 1, 0, 9, 9), 0, 17, 0};
        tbl[3] = '{mk(7, 3, 1, 3, 0, 0), 0, 20, 3};
        tbl[4] = '{mk(49, 3, 0, 1, 1, 0), 0, 18, 1};
        tbl[5] = '{mk(0, 0, 1, 2, 2, 1), 0, 22, 4};
        tbl[6] = '{mk(63, 2, 1, 1, 1, 1), 1, 0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset outs", 32'(obs() & 8'h7f), 32'h0);
        check("reset addr", {vdec_addr, hdec_addr}, 8'h0);
        rst_n = 1'b1;
        #1;
        check("ready after reset", 32'(cmd_ready), 32'h1);

        // Table vectors; the first is accepted on the first edge.
        for (int i = 0; i < 7; i++) begin
            run_cmd(tbl[i].c, bit'(i % 2), i == 0, len, high, nerr);
            check($sformatf("tbl%0d len", i), len, tbl[i].exp_len);
            check($sformatf("tbl%0d high", i), high, tbl[i].exp_high);
            check($sformatf("tbl%0d err", i), nerr, tbl[i].exp_err);
        end

        // Reset in the middle of a pulse
        @(negedge clk);
        drive(mk(12, 2, 0, 3, 5, 2), 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (vinj_pulse !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach pulse", 32'(n < 40), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid pulse", 32'(obs() & 8'h7f), 32'h0);
        check("rst mid addr", {vdec_addr, hdec_addr}, 8'h0);
        exp_row = '0;
        exp_col = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post rst idle", 32'(obs()), 32'h80);
        end
        run_cmd(mk(33, 1, 0, 2, 3, 1), 1'b0, 1'b0, len, high, nerr);
        check("post rst len", len, 24);

        // cmd_valid held high: one command per return to idle
        c = mk(20, 1, 1, 1, 2, 0);
        @(negedge clk);
        drive(c, 1'b1);
        exp_row = c.row;
        exp_col = c.col;
        ndone = 0;
        for (int i = 1; i <= 3 * (done_at(c) + 1); i++) begin
            @(negedge clk);
            check($sformatf("held i%0d", i), 32'(obs()),
                  32'(exp_vec(c, ((i - 1) % (done_at(c) + 1)) + 1)));
            if (done) ndone++;
        end
        cmd_valid = 1'b0;
        check("held done count", ndone, 3);

        // Random commands
        for (int i = 0; i < 25; i++) begin
            c = mk(int'($urandom_range(0, 55)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
            run_cmd(c, 1'b1, 1'b0, len, high, nerr);
            check($sformatf("rnd%0d len", i), len, done_at(c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fg_prog_sequencer.md
FG_PROG_SEQUENCER -- requirements
Module: fg_prog_sequencer

Drives the island programming mux (vertical/horizontal Vinj decoders, drain select, prog switches) with timed injection/tunnel pulse trains for one floating-gate cell per command.

Interface
- REQ-001 Parameter NUM_ROWS, default 50: rows in the target island matrix.
- REQ-002 Parameter NUM_COLS, default 4: columns in the target island (4x2 indirect tile plus TGate B-matrix).
- REQ-003 Parameter ROW_W, default 6: row address width (ceil log2 NUM_ROWS).
- REQ-004 Parameter COL_W, default 2: column address width.
- REQ-005 Parameter SETTLE, default 8: cycles for which the address/switch state must be stable before and after pulses.
- REQ-006 Port clk, input, 1: sole clock, rising edge.
- REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
- REQ-008 Port cmd_valid, input, 1: command offered.
- REQ-009 Port cmd_ready, output, 1: sequencer accepts a command this cycle.
- REQ-010 Ports cmd_row (ROW_W), cmd_col (COL_W), inputs: target cell.
- REQ-011 Port cmd_mode, input, 1: 0 = injection, 1 = tunnelling.
- REQ-012 Port cmd_npulse, input, 8: pulse count; 0 = select/deselect only.
- REQ-013 Port cmd_width, input, 16: pulse high time in cycles; 0 treated as 1.
- REQ-014 Port cmd_gap, input, 16: low time between pulses in cycles.
- REQ-015 Port vdec_addr, output, ROW_W: vertical decoder address.
- REQ-016 Port hdec_addr, output, COL_W: horizontal decoder address.
- REQ-017 Ports prog_sel, drain_sel, outputs, 1 each: route the prog switch and drain select to the addressed cell.
- REQ-018 Ports vinj_pulse, tun_pulse, outputs, 1 each: registered high-voltage pulse enables.
- REQ-019 Ports busy, done, err, outputs, 1 each: status; done and err are single-cycle pulses.

Function
- REQ-020 States IDLE, SETUP, PULSE, GAP, RELEASE, DONE; every output is registered.
- REQ-021 cmd_ready = 1 only in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both 1.
- REQ-022 Accepting a command with cmd_row >= NUM_ROWS or cmd_col >= NUM_COLS pulses err for 1 cycle, stays in IDLE, and leaves all switch outputs low.
- REQ-023 Accepting a valid command latches all fields, drives vdec_addr/hdec_addr, sets prog_sel = drain_sel = 1 and busy = 1, and enters SETUP.
- REQ-024 SETUP lasts exactly SETTLE cycles, then goes to PULSE, or to RELEASE if npulse = 0.
- REQ-025 PULSE asserts vinj_pulse (mode 0) or tun_pulse (mode 1) for exactly max(width,1) cycles. The other pulse enable stays 0.
- REQ-026 After each pulse the remaining count decrements. At 0 the block goes to RELEASE; otherwise it goes to GAP for cmd_gap cycles (gap 0 goes straight to the next PULSE with no low cycle).
- REQ-027 vinj_pulse and tun_pulse are never both 1. Neither is 1 outside PULSE.
- REQ-028 RELEASE holds addresses and selects for SETTLE cycles with both pulse enables 0. It then clears prog_sel/drain_sel and enters DONE.
- REQ-029 DONE lasts 1 cycle: done = 1, busy = 0 on the next cycle, return to IDLE.
- REQ-030 Addresses change only on command acceptance. They retain their last value in IDLE.
- REQ-031 cmd_valid during a busy command is ignored (not accepted, not queued). Command inputs may change freely while busy.
- REQ-032 Counters are 16-bit (timing) and 8-bit (pulse count), cannot wrap, and are reloaded on each state entry.

Reset
- REQ-033 rst_n low asynchronously forces IDLE, with all outputs 0 except cmd_ready = 1 after release. vdec_addr = hdec_addr = 0.
- REQ-034 Reset during PULSE drops vinj_pulse/tun_pulse in the same instant, with no completion done.
- REQ-035 The first command may be accepted on the first rising edge after rst_n deasserts.

Verification
- REQ-036 row 3, col 1, mode 0, npulse 2, width 4, gap 3, SETTLE 8 -> vinj_pulse high 4, low 3, high 4 cycles; done 8 cycles after the last pulse plus 1; tun_pulse always 0.
- REQ-037 row 50 -> err 1 cycle, cmd_ready stays 1, prog_sel/drain_sel stay 0.
- REQ-038 npulse 0 -> selects high for 2*SETTLE = 16 cycles, no pulse, then done.
- REQ-039 width 0, gap 0, npulse 3, mode 1 -> tun_pulse high for 3 consecutive cycles.
- REQ-040 rst_n low mid-PULSE -> pulse and selects 0 immediately, no done; the next command proceeds normally.
- REQ-041 cmd_valid held high during a busy command -> exactly one command accepted per return to IDLE.
